// File: rtl/fft_wr_sched_if.sv
// Port bundle between the FFT write-path sequencer (master) and the two-bank BRAM datapath.
interface fft_wr_sched_if #(
  parameter int N_LOG2 = 4,
  parameter int AW     = N_LOG2 - 1
);
  // ext_valid/ext_ready: a sample transfers in any cycle where both are high; dropping ext_valid stalls with no write.
  logic              start;
  logic              busy;
  logic              done;
  logic              ext_valid;
  logic              ext_ready;
  logic              en_REG_WR;
  logic              sel_din;
  logic              sel_wr_bank;
  logic              sel_wr_swap;
  logic              we_bank0;
  logic              we_bank1;
  logic [AW-1:0]     wr_addr_bank0;
  logic [AW-1:0]     wr_addr_bank1;
  logic              rd_en;
  logic [AW-1:0]     rd_addr_bank0;
  logic [AW-1:0]     rd_addr_bank1;
  logic              rd_swap;
  logic [N_LOG2-2:0] tw_idx;

  modport master (
    input  start, ext_valid,
    output busy, done, ext_ready, en_REG_WR, sel_din, sel_wr_bank, sel_wr_swap,
           we_bank0, we_bank1, wr_addr_bank0, wr_addr_bank1,
           rd_en, rd_addr_bank0, rd_addr_bank1, rd_swap, tw_idx
  );

  modport slave (
    output start, ext_valid,
    input  busy, done, ext_ready, en_REG_WR, sel_din, sel_wr_bank, sel_wr_swap,
           we_bank0, we_bank1, wr_addr_bank0, wr_addr_bank1,
           rd_en, rd_addr_bank0, rd_addr_bank1, rd_swap, tw_idx
  );
endinterface

// File: rtl/fft_wr_sched.sv
// Load/issue/drain sequencer for the two-bank radix-2 DIF FFT memory: parity-mapped sample load,
// one butterfly read per cycle, and a latency-matched tracking pipe that drives the result writes.
module fft_wr_sched #(
  parameter int N_LOG2 = 4,
  parameter int AW     = N_LOG2 - 1,
  parameter int BF_LAT = 3
) (
  input  logic           clk,
  input  logic           rst,
  fft_wr_sched_if.master io,
  output logic [2:0]     state_dbg
);
  localparam int N     = 1 << N_LOG2;
  localparam int DEPTH = BF_LAT + 2;
  localparam int SW    = $clog2(N_LOG2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [N_LOG2-1:0] n_cnt;
  logic [AW-1:0]     b_cnt;
  logic [SW-1:0]     s_cnt;
  logic [3:0]        d_cnt;

  logic accept, last_n, last_b, last_d, last_s, par_n;

  assign state_dbg = state;
  assign accept    = (state == S_LOAD) && io.ext_valid;
  assign last_n    = &n_cnt;
  assign last_b    = &b_cnt;
  assign last_d    = (d_cnt == 4'(DEPTH - 1));
  assign last_s    = (s_cnt == SW'(N_LOG2 - 1));
  assign par_n     = ^n_cnt;

  // Butterfly operand indices: i keeps b's low (b mod h) bits and shifts the group number up one place.
  logic [N_LOG2-1:0] h_full, idx_i;
  logic [AW-1:0]     mask, b_lo, b_hi, i_addr, j_addr, tw;
  logic              par_i;

  assign h_full = N_LOG2'(N / 2) >> s_cnt;
  assign mask   = h_full[AW-1:0] - AW'(1);
  assign b_lo   = b_cnt & mask;
  assign b_hi   = b_cnt & ~mask;
  assign idx_i  = {b_hi, 1'b0} | {1'b0, b_lo};
  assign par_i  = ^idx_i;
  assign i_addr = idx_i[N_LOG2-1:1];
  assign j_addr = i_addr | h_full[N_LOG2-1:1];
  assign tw     = b_lo << s_cnt;

  // Tracking pipe: slot k holds the butterfly read k+1 cycles ago.
  logic [DEPTH-1:0] pv, pp;
  logic [AW-1:0]    pia [DEPTH];
  logic [AW-1:0]    pja [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      pp <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        pia[k] <= '0;
        pja[k] <= '0;
      end
    end else begin
      pv     <= {pv[DEPTH-2:0], state == S_ISSUE};
      pp     <= {pp[DEPTH-2:0], par_i};
      pia[0] <= i_addr;
      pja[0] <= j_addr;
      for (int k = 1; k < DEPTH; k++) begin
        pia[k] <= pia[k-1];
        pja[k] <= pja[k-1];
      end
    end
  end

  logic          wb_v, wb_p;
  logic [AW-1:0] wb_ia, wb_ja;

  assign wb_v  = pv[DEPTH-1];
  assign wb_p  = pp[DEPTH-1];
  assign wb_ia = pia[DEPTH-1];
  assign wb_ja = pja[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (io.start) state_nxt = S_LOAD;
      S_LOAD:  if (accept && last_n) state_nxt = S_ISSUE;
      S_ISSUE: if (last_b) state_nxt = S_DRAIN;
      S_DRAIN: if (last_d) state_nxt = last_s ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // b wraps to 0 on its last value, so each stage restarts without an explicit clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_cnt <= '0;
      b_cnt <= '0;
      s_cnt <= '0;
      d_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          n_cnt <= '0;
          b_cnt <= '0;
          s_cnt <= '0;
          d_cnt <= '0;
        end
        S_LOAD:  if (accept) n_cnt <= n_cnt + 1'b1;
        S_ISSUE: b_cnt <= b_cnt + 1'b1;
        S_DRAIN: begin
          if (last_d) begin
            d_cnt <= '0;
            s_cnt <= s_cnt + 1'b1;
          end else begin
            d_cnt <= d_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    io.busy          = (state != S_IDLE);
    io.done          = (state == S_DONE);
    io.ext_ready     = 1'b0;
    io.en_REG_WR     = pv[BF_LAT];
    io.sel_din       = 1'b0;
    io.sel_wr_bank   = 1'b0;
    io.sel_wr_swap   = 1'b0;
    io.we_bank0      = 1'b0;
    io.we_bank1      = 1'b0;
    io.wr_addr_bank0 = '0;
    io.wr_addr_bank1 = '0;
    io.rd_en         = 1'b0;
    io.rd_addr_bank0 = '0;
    io.rd_addr_bank1 = '0;
    io.rd_swap       = 1'b0;
    io.tw_idx        = '0;

    if (wb_v) begin
      io.we_bank0    = 1'b1;
      io.we_bank1    = 1'b1;
      io.sel_wr_swap = ~wb_p;
      if (wb_p) begin
        io.wr_addr_bank1 = wb_ia;
        io.wr_addr_bank0 = wb_ja;
      end else begin
        io.wr_addr_bank0 = wb_ia;
        io.wr_addr_bank1 = wb_ja;
      end
    end

    case (state)
      S_LOAD: begin
        io.ext_ready = 1'b1;
        io.sel_din   = 1'b1;
        if (io.ext_valid) begin
          io.sel_wr_bank = par_n;
          io.we_bank1    = par_n;
          io.we_bank0    = ~par_n;
          if (par_n) io.wr_addr_bank1 = n_cnt[N_LOG2-1:1];
          else       io.wr_addr_bank0 = n_cnt[N_LOG2-1:1];
        end
      end
      S_ISSUE: begin
        io.rd_en   = 1'b1;
        io.rd_swap = par_i;
        io.tw_idx  = tw;
        if (par_i) begin
          io.rd_addr_bank1 = i_addr;
          io.rd_addr_bank0 = j_addr;
        end else begin
          io.rd_addr_bank0 = i_addr;
          io.rd_addr_bank1 = j_addr;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fft_wr_sched.sv
// Scoreboarded bench for fft_wr_sched at N=16, BF_LAT=3: cycle-stamped expected writes/reads/
// en_REG_WR/done are queued by the drivers and matched by an independent negedge monitor.
module tb_fft_wr_sched;
  localparam int N_LOG2    = 4;
  localparam int AW        = 3;
  localparam int BF_LAT    = 3;
  localparam int N         = 16;
  localparam int STAGE_CYC = N / 2 + BF_LAT + 2;
  localparam int WR_W      = 32 + 5 + 2 * AW;
  localparam int RD_W      = 32 + 1 + 3 * AW;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [WR_W-1:0] wr_q[$];
  logic [RD_W-1:0] rd_q[$];
  int              en_q[$];
  int              done_q[$];

  // bit n = parity of n
  logic [15:0] par_tab = 16'h6996;
  // i for each (stage, b), written out by hand
  int i_tab [4][8] = '{'{0, 1, 2, 3, 4, 5, 6, 7},
                       '{0, 1, 2, 3, 8, 9, 10, 11},
                       '{0, 1, 4, 5, 8, 9, 12, 13},
                       '{0, 2, 4, 6, 8, 10, 12, 14}};

  fft_wr_sched_if #(.N_LOG2(N_LOG2), .AW(AW)) sif ();

  fft_wr_sched #(.N_LOG2(N_LOG2), .AW(AW), .BF_LAT(BF_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (sif),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void no_exp(string name);
    checks++;
    errors++;
    $display("FAIL %s: event at cycle %0d with nothing expected", name, cyc);
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [WR_W-1:0] act_wr;
    logic [RD_W-1:0] act_rd;
    act_wr = {cyc, sif.we_bank0, sif.we_bank1, sif.sel_wr_bank, sif.sel_wr_swap, sif.sel_din,
              sif.wr_addr_bank0, sif.wr_addr_bank1};
    act_rd = {cyc, sif.rd_swap, sif.rd_addr_bank0, sif.rd_addr_bank1, sif.tw_idx};
    if (sif.we_bank0 || sif.we_bank1) begin
      if (wr_q.size() == 0) no_exp("write");
      else check("write", 64'(act_wr), 64'(wr_q.pop_front()));
    end
    if (sif.rd_en) begin
      if (rd_q.size() == 0) no_exp("read");
      else check("read", 64'(act_rd), 64'(rd_q.pop_front()));
    end
    if (sif.en_REG_WR) begin
      if (en_q.size() == 0) no_exp("en_REG_WR");
      else check("en_REG_WR_cycle", 64'(cyc), 64'(en_q.pop_front()));
    end
    if (sif.done) begin
      if (done_q.size() == 0) no_exp("done");
      else begin
        check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        check("busy_at_done", 64'(sif.busy), 64'd1);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string name);
    logic [28:0] outs;
    outs = {state_dbg, sif.busy, sif.done, sif.ext_ready, sif.en_REG_WR, sif.sel_din,
            sif.sel_wr_bank, sif.sel_wr_swap, sif.we_bank0, sif.we_bank1, sif.wr_addr_bank0,
            sif.wr_addr_bank1, sif.rd_en, sif.rd_addr_bank0, sif.rd_addr_bank1, sif.rd_swap,
            sif.tw_idx};
    check(name, 64'(outs), 64'd0);
  endtask

  task automatic push_wr(input int c, input bit we0, input bit we1, input bit bank,
                         input bit swap, input bit din, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1);
    wr_q.push_back({c, we0, we1, bank, swap, din, a0, a1});
  endtask

  task automatic load_run(input bit gaps, output int t0);
    bit p;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int n = 0; n < N; n++) begin
      if (gaps && (n % 3 == 1)) begin
        sif.ext_valid = 1'b0;
        check("ext_ready_gap", 64'(sif.ext_ready), 64'd1);
        tick();
      end
      sif.ext_valid = 1'b1;
      p = par_tab[n];
      push_wr(cyc, !p, p, p, 1'b0, 1'b1, p ? AW'(0) : AW'(n >> 1), p ? AW'(n >> 1) : AW'(0));
      check("ext_ready_load", 64'({sif.ext_ready, sif.busy}), 64'd3);
      tick();
    end
    sif.ext_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic push_compute(input int t0);
    int h, i, j, rc;
    bit p;
    logic [AW-1:0] ai, aj, ra0, ra1, tw;
    for (int s = 0; s < N_LOG2; s++) begin
      h = (N / 2) >> s;
      for (int b = 0; b < N / 2; b++) begin
        i   = i_tab[s][b];
        j   = i + h;
        p   = par_tab[i];
        rc  = t0 + s * STAGE_CYC + b;
        ai  = AW'(i >> 1);
        aj  = AW'(j >> 1);
        ra0 = p ? aj : ai;
        ra1 = p ? ai : aj;
        tw  = AW'((i % h) * (1 << s));
        rd_q.push_back({rc, p, ra0, ra1, tw});
        en_q.push_back(rc + BF_LAT + 1);
        push_wr(rc + BF_LAT + 2, 1'b1, 1'b1, 1'b0, !p, 1'b0, ra0, ra1);
      end
    end
    done_q.push_back(t0 + N_LOG2 * STAGE_CYC);
  endtask

  task automatic check_drained(string tag);
    check({tag, "_wr_q_left"}, 64'(wr_q.size()), 64'd0);
    check({tag, "_rd_q_left"}, 64'(rd_q.size()), 64'd0);
    check({tag, "_en_q_left"}, 64'(en_q.size()), 64'd0);
    check({tag, "_done_q_left"}, 64'(done_q.size()), 64'd0);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    sif.start = 1'b0;
    sif.ext_valid = 1'b0;
    tick();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    rst = 1'b0;
    check_idle("reset_outputs");
    tick();
    check_idle("start_during_reset");

    // run 1: loading with gaps, a stray start mid-compute
    load_run(1'b1, t0);
    push_compute(t0);
    while (cyc < t0 + 20) tick();
    check("ext_ready_compute", 64'({sif.ext_ready, sif.busy}), 64'd1);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    while (cyc < t0 + N_LOG2 * STAGE_CYC + 1) tick();
    check_idle("idle_after_done");
    repeat (3) tick();
    check_idle("idle_after_busy_start");
    check_drained("run1");

    // run 2: abort in stage 1 mid-issue
    load_run(1'b0, t0);
    push_compute(t0);
    while (cyc < t0 + STAGE_CYC + 3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_q.delete();
    rd_q.delete();
    en_q.delete();
    done_q.delete();
    check_idle("abort_outputs");
    repeat (10) tick();
    check_idle("abort_stays_idle");

    // run 3: reload after abort, runs to completion
    load_run(1'b1, t0);
    push_compute(t0);
    while (cyc < t0 + N_LOG2 * STAGE_CYC + 1) tick();
    check_idle("idle_after_rerun");
    repeat (2) tick();
    check_drained("run3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
